// File: rtl/morse_encoder.sv
// morse_encoder: turns one character code (A..Z, 0..9) into ITU Morse timing
// on a registered key line, with dot/dash strobes on the first mark cycle of
// each element. One Morse unit is UNIT_CYCLES clocks.
// Build option: define MORSE_WORD_GAP_EN to make code 63 a legal word space
// (7 silent units in WORD_GAP); without it, code 63 is an unsupported code.
module morse_encoder #(
   parameter int UNIT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       char_valid,
   input  logic [5:0] char_code,
   output logic       char_ready,
   output logic       key,
   output logic       dot,
   output logic       dash,
   output logic       busy,
   output logic       err
);

   localparam int             CW        = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0]  UNIT_LAST = CW'(UNIT_CYCLES - 1);

`ifdef MORSE_WORD_GAP_EN
   typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP} state_t;
`endif

   // Returns {element count, pattern}; the pattern is left-aligned with the
   // first element in bit 4, 1 = dash, 0 = dot.
   function automatic logic [7:0] lookup(input logic [5:0] code);
      case (code)
         6'd0:  lookup = {3'd2, 5'b01000};  // A .-
         6'd1:  lookup = {3'd4, 5'b10000};  // B -...
         6'd2:  lookup = {3'd4, 5'b10100};  // C -.-.
         6'd3:  lookup = {3'd3, 5'b10000};  // D -..
         6'd4:  lookup = {3'd1, 5'b00000};  // E .
         6'd5:  lookup = {3'd4, 5'b00100};  // F ..-.
         6'd6:  lookup = {3'd3, 5'b11000};  // G --.
         6'd7:  lookup = {3'd4, 5'b00000};  // H ....
         6'd8:  lookup = {3'd2, 5'b00000};  // I ..
         6'd9:  lookup = {3'd4, 5'b01110};  // J .---
         6'd10: lookup = {3'd3, 5'b10100};  // K -.-
         6'd11: lookup = {3'd4, 5'b01000};  // L .-..
         6'd12: lookup = {3'd2, 5'b11000};  // M --
         6'd13: lookup = {3'd2, 5'b10000};  // N -.
         6'd14: lookup = {3'd3, 5'b11100};  // O ---
         6'd15: lookup = {3'd4, 5'b01100};  // P .--.
         6'd16: lookup = {3'd4, 5'b11010};  // Q --.-
         6'd17: lookup = {3'd3, 5'b01000};  // R .-.
         6'd18: lookup = {3'd3, 5'b00000};  // S ...
         6'd19: lookup = {3'd1, 5'b10000};  // T -
         6'd20: lookup = {3'd3, 5'b00100};  // U ..-
         6'd21: lookup = {3'd4, 5'b00010};  // V ...-
         6'd22: lookup = {3'd3, 5'b01100};  // W .--
         6'd23: lookup = {3'd4, 5'b10010};  // X -..-
         6'd24: lookup = {3'd4, 5'b10110};  // Y -.--
         6'd25: lookup = {3'd4, 5'b11000};  // Z --..
         6'd26: lookup = {3'd5, 5'b11111};  // 0 -----
         6'd27: lookup = {3'd5, 5'b01111};  // 1 .----
         6'd28: lookup = {3'd5, 5'b00111};  // 2 ..---
         6'd29: lookup = {3'd5, 5'b00011};  // 3 ...--
         6'd30: lookup = {3'd5, 5'b00001};  // 4 ....-
         6'd31: lookup = {3'd5, 5'b00000};  // 5 .....
         6'd32: lookup = {3'd5, 5'b10000};  // 6 -....
         6'd33: lookup = {3'd5, 5'b11000};  // 7 --...
         6'd34: lookup = {3'd5, 5'b11100};  // 8 ---..
         6'd35: lookup = {3'd5, 5'b11110};  // 9 ----.
         default: lookup = 8'd0;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;      // cycle within the current unit
   logic [2:0]      units_q, units_d;  // whole units spent in the current state
   logic [4:0]      pat_q, pat_d;      // remaining elements, current one in bit 4
   logic [2:0]      left_q, left_d;    // elements left including the current one
   logic            key_q, key_d;
   logic            dot_q, dot_d;
   logic            dash_q, dash_d;
   logic            err_q, err_d;

   logic [7:0]      lut;
   logic            accept, legal_char, is_word, unit_tick, mark_done;
   logic            enter_mark, elem_dash;

   assign lut        = lookup(char_code);
   assign accept     = char_valid && (state_q == IDLE);
   assign legal_char = (char_code <= 6'd35);
`ifdef MORSE_WORD_GAP_EN
   assign is_word    = (char_code == 6'd63);
`else
   assign is_word    = 1'b0;
`endif
   assign unit_tick  = (cnt_q == UNIT_LAST);
   assign mark_done  = unit_tick && (units_q == (pat_q[4] ? 3'd2 : 3'd0));

   // State register and all datapath flops; reset abandons any character.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values computed by the combinational processes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         units_q <= '0;
         pat_q   <= '0;
         left_q  <= '0;
         key_q   <= 1'b0;
         dot_q   <= 1'b0;
         dash_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         units_q <= units_d;
         pat_q   <= pat_d;
         left_q  <= left_d;
         key_q   <= key_d;
         dot_q   <= dot_d;
         dash_q  <= dash_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: element timing is measured in whole units.
   // NOTE: the default assignment first means every path assigns state_d,
   // so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal_char)   state_d = MARK;
`ifdef MORSE_WORD_GAP_EN
               else if (is_word) state_d = WORD_GAP;
`endif
            end
         end
         MARK:     if (mark_done) state_d = (left_q > 3'd1) ? ELEM_GAP : CHAR_GAP;
         ELEM_GAP: if (unit_tick) state_d = MARK;
         CHAR_GAP: if (unit_tick && units_q == 3'd2) state_d = IDLE;
`ifdef MORSE_WORD_GAP_EN
         WORD_GAP: if (unit_tick && units_q == 3'd6) state_d = IDLE;
`endif
         default:  state_d = IDLE;
      endcase
   end

   // Output and datapath logic: counters restart on every state change,
   // the pattern shifts as each mark ends, strobes mark the first key cycle.
   always_comb begin
      cnt_d   = (state_d != state_q || unit_tick || state_q == IDLE) ? '0 : cnt_q + CW'(1);
      units_d = (state_d != state_q || state_q == IDLE) ? 3'd0 : units_q + {2'b00, unit_tick};
      pat_d   = pat_q;
      left_d  = left_q;
      if (accept && legal_char) begin
         pat_d  = lut[4:0];
         left_d = lut[7:5];
      end else if (state_q == MARK && mark_done) begin
         pat_d  = {pat_q[3:0], 1'b0};
         left_d = left_q - 3'd1;
      end
      enter_mark = (state_d == MARK) && (state_q != MARK);
      elem_dash  = (state_q == IDLE) ? lut[4] : pat_q[4];
      key_d      = (state_d == MARK);
      dot_d      = enter_mark && !elem_dash;
      dash_d     = enter_mark && elem_dash;
      err_d      = accept && !legal_char && !is_word;
   end

   assign char_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign key        = key_q;
   assign dot        = dot_q;
   assign dash       = dash_q;
   assign err        = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: scoreboard bench for morse_encoder with UNIT_CYCLES=4.
// On every accept the bench expands its own Morse table into a per-cycle
// trace of {key, dot, dash, busy, char_ready, err}; a negedge monitor pops
// one entry per cycle (or expects idle when the queue is empty).
module tb_morse_encoder;

   localparam int U = 4;
   localparam logic [5:0] IDLE_V = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       char_valid = 1'b0;
   logic [5:0] char_code = 6'd0;
   logic       char_ready, key, dot, dash, busy, err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_cyc = 0;
   bit mon_en = 1'b0;
   logic [5:0] exp_q[$];

   string morse_tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-",
      ".....", "-....", "--...", "---..", "----."};

   morse_encoder #(.UNIT_CYCLES(U)) dut (
      .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_code(char_code),
      .char_ready(char_ready), .key(key), .dot(dot), .dash(dash),
      .busy(busy), .err(err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected cycles 1..N after an accept, ending with the first ready cycle.
   task automatic push_trace(input logic [5:0] code);
      string s;
      int    len;
      bit    is_dash;
      if (code <= 6'd35) begin
         s = morse_tab[code];
         for (int i = 0; i < s.len(); i++) begin
            is_dash = (s[i] == "-");
            len = is_dash ? 3 * U : U;
            for (int c = 0; c < len; c++)
               exp_q.push_back({1'b1, (c == 0) && !is_dash, (c == 0) && is_dash, 1'b1, 1'b0, 1'b0});
            len = (i == s.len() - 1) ? 3 * U : U;
            for (int c = 0; c < len; c++) exp_q.push_back(6'b000100);
         end
         exp_q.push_back(IDLE_V);
`ifdef MORSE_WORD_GAP_EN
      end else if (code == 6'd63) begin
         for (int c = 0; c < 7 * U; c++) exp_q.push_back(6'b000100);
         exp_q.push_back(IDLE_V);
`endif
      end else begin
         exp_q.push_back(6'b000011);
      end
   endtask

   // Bench-side accept: the bench expects readiness exactly when its queue is empty.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && mon_en && char_valid && exp_q.size() == 0) begin
         push_trace(char_code);
         acc_cnt++;
         acc_cyc = cyc;
      end
   end

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      logic [5:0] e;
      if (mon_en) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_V;
         check($sformatf("out@%0d", cyc), {26'd0, key, dot, dash, busy, char_ready, err}, {26'd0, e});
      end
   end

   // Raise char_valid with a code and hold it until the bench sees the accept.
   task automatic send(input logic [5:0] c);
      int n;
      int k;
      @(negedge clk); #1;
      char_valid = 1'b1;
      char_code  = c;
      n = acc_cnt;
      k = 0;
      while (acc_cnt == n && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("accept_%0d", c), 32'(acc_cnt != n), 32'd1);
   endtask

   // Wait for the trace to drain, wiggling the inputs while the DUT is busy.
   task automatic wait_idle();
      int k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(negedge clk); #1;
         if (exp_q.size() > 1) begin
            char_valid = 1'($urandom_range(0, 1));
            char_code  = 6'($urandom_range(0, 63));
         end else begin
            char_valid = 1'b0;
         end
         k++;
      end
      char_valid = 1'b0;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_key", 32'(key), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      send(6'd4);  wait_idle();                    // E
      send(6'd0);  wait_idle();                    // A
      send(6'd26); send(6'd19); wait_idle();       // digit 0 then T back-to-back
      send(6'd40); wait_idle();                    // unsupported
      send(6'd63); wait_idle();                    // word gap or unsupported
      send(6'd35); wait_idle();                    // 9 (last legal code)
      send(6'd36); wait_idle();                    // first unsupported code
      for (int i = 0; i < 6; i++) begin
         send(6'($urandom_range(0, 35)));
         wait_idle();
      end

      // Reset in the middle of a T mark: key drops at once, nothing resumes.
      send(6'd19);
      char_valid = 1'b0;
      while (cyc < acc_cyc + 6) @(posedge clk);
      #2;
      mon_en = 1'b0;
      exp_q.delete();
      check("pre_rst_key", 32'(key), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_key", 32'(key), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_dash", 32'(dash), 32'd0);
      check("async_ready", 32'(char_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (20) @(negedge clk);                  // idle expected: no resumption
      send(6'd10); wait_idle();                    // K after reset
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
